curve_lut_ctrl: RTL and testbench

Adaptive controller for the dark-enhancement brightness curve. It measures mean luma per frame and derives a blend strength alpha from it. During the following frame it regenerates a 256-entry shadow LUT by blending the identity mapping with the fixed base curve, which it reads through an external table port. At the next frame start it swaps the shadow bank in, so the live pixel path always maps through a complete, stable table.

---
 rtl/curve_lut_ctrl_if.sv | 26 ++
 rtl/curve_lut_ctrl.sv | 120 ++++++++++++
 tb/tb_curve_lut_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/curve_lut_ctrl_if.sv
// rtl/curve_lut_ctrl_if.sv - pixel, statistics and base-curve table signals of curve_lut_ctrl
interface curve_lut_ctrl_if;
  logic       i_en;
  logic       i_vsync;
  logic       i_de;
  logic [7:0] i_y;
  logic       o_de;
  logic [7:0] o_y;
  logic [7:0] o_tab_addr;
  logic [7:0] i_tab_data;
  logic [4:0] o_alpha;
  logic       o_ready;
  logic       o_busy;

  // Upstream side: video source plus the base-curve table
  modport master (
    output i_en, i_vsync, i_de, i_y, i_tab_data,
    input  o_de, o_y, o_tab_addr, o_alpha, o_ready, o_busy
  );

  // Controller side
  modport slave (
    input  i_en, i_vsync, i_de, i_y, i_tab_data,
    output o_de, o_y, o_tab_addr, o_alpha, o_ready, o_busy
  );
endinterface

// File: rtl/curve_lut_ctrl.sv
// rtl/curve_lut_ctrl.sv - adaptive dark-enhancement curve with double-buffered LUT
module curve_lut_ctrl #(
  parameter int FRAME_PIX_LOG2 = 16,
  parameter int ALPHA_SHIFT    = 4
) (
  input logic             clk,
  input logic             rst,
  curve_lut_ctrl_if.slave bus
);

  localparam int SW = 8 + FRAME_PIX_LOG2 + 1;

  typedef enum logic [1:0] {COLLECT, CALC, FILL, DONE} state_t;

  state_t        state;
  logic [SW-1:0] sum;
  logic [7:0]    mean;
  logic [7:0]    cnt;
  logic [4:0]    alpha;
  logic          active;
  logic          ready;

  logic [7:0]    bank [0:511];
  logic [7:0]    rd_data;
  logic [7:0]    y_q;
  logic          ready_q;
  logic          de_q;

  // Saturating luma accumulator and frame mean
  logic [SW:0]   sum_add;
  logic [SW-1:0] sum_sat;
  logic [SW-1:0] sum_shift;
  logic [7:0]    mean_next;
  assign sum_add   = {1'b0, sum} + {{(SW-7){1'b0}}, bus.i_y};
  assign sum_sat   = sum_add[SW] ? {SW{1'b1}} : sum_add[SW-1:0];
  assign sum_shift = sum >> FRAME_PIX_LOG2;
  assign mean_next = (|sum_shift[SW-1:8]) ? 8'hff : sum_shift[7:0];

  // Darker frames get a stronger pull toward the base curve
  logic [7:0] mean_q;
  logic [4:0] alpha_calc;
  assign mean_q     = mean >> (8 - ALPHA_SHIFT);
  assign alpha_calc = bus.i_en ? (5'(1 << ALPHA_SHIFT) - mean_q[4:0]) : 5'd0;

  // Blend identity with base curve for the current fill entry, clamped to 8 bits
  logic signed [15:0] diff;
  logic signed [15:0] prod;
  logic signed [15:0] blend;
  logic [7:0]         wr_data;
  logic               wr_en;
  assign diff    = $signed({8'd0, bus.i_tab_data}) - $signed({8'd0, cnt});
  assign prod    = diff * $signed({11'd0, alpha});
  assign blend   = $signed({8'd0, cnt}) + (prod >>> ALPHA_SHIFT);
  assign wr_data = (blend < 0) ? 8'd0 : (blend > 255) ? 8'd255 : blend[7:0];
  // A frame start during FILL aborts the entry in flight
  assign wr_en   = (state == FILL) && !bus.i_vsync;

  // Statistics, bank swap and fill sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= COLLECT;
      sum    <= '0;
      mean   <= '0;
      cnt    <= '0;
      alpha  <= '0;
      active <= 1'b0;
      ready  <= 1'b0;
    end else if (bus.i_vsync) begin
      mean  <= mean_next;
      sum   <= bus.i_de ? {{(SW-8){1'b0}}, bus.i_y} : '0;
      state <= CALC;
      // Only a completely filled shadow bank is ever swapped in
      if (state == DONE) begin
        active <= ~active;
        ready  <= 1'b1;
      end
    end else begin
      if (bus.i_de) sum <= sum_sat;
      case (state)
        CALC: begin
          alpha <= alpha_calc;
          cnt   <= '0;
          state <= FILL;
        end
        FILL: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'd255) state <= DONE;
        end
        default: ;
      endcase
    end
  end

  // Bank RAM: fill writes the shadow half, pixel path reads the active half
  always_ff @(posedge clk) begin
    if (wr_en) bank[{~active, cnt}] <= wr_data;
    rd_data <= bank[{active, bus.i_y}];
  end

  // Pixel-path side registers that select between RAM output and bypass
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      ready_q <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      y_q     <= bus.i_y;
      ready_q <= ready;
      de_q    <= bus.i_de;
    end
  end

  assign bus.o_y        = ready_q ? rd_data : y_q;
  assign bus.o_de       = de_q;
  assign bus.o_tab_addr = cnt;
  assign bus.o_alpha    = alpha;
  assign bus.o_ready    = ready;
  assign bus.o_busy     = (state == CALC) || (state == FILL);

endmodule

// File: tb/tb_curve_lut_ctrl.sv
// tb/tb_curve_lut_ctrl.sv - directed bench for curve_lut_ctrl
module tb_curve_lut_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  curve_lut_ctrl_if bus ();

  curve_lut_ctrl #(.FRAME_PIX_LOG2(4), .ALPHA_SHIFT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Base curve: base(1)=2, base(128)=175, base(0)=0, base(255)=255
  function automatic logic [7:0] base_curve(input logic [7:0] a);
    int x;
    x = a;
    return 8'(x + (((255 - x) * x * 47) >> 14) + ((x > 0 && x < 255) ? 1 : 0));
  endfunction

  always_comb bus.i_tab_data = base_curve(bus.o_tab_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [7:0] y, input logic [7:0] exp);
    bus.i_y = y;
    tick();
    check(tag, {24'd0, bus.o_y}, {24'd0, exp});
  endtask

  // n pixels of value val, then a vsync cycle with i_y=vy (de low)
  task automatic frame_vsync(input int val, input int n, input logic [7:0] vy);
    for (int i = 0; i < n; i++) begin
      bus.i_de = 1'b1;
      bus.i_y  = 8'(val);
      tick();
    end
    bus.i_de    = 1'b0;
    bus.i_y     = vy;
    bus.i_vsync = 1'b1;
    tick();
    bus.i_vsync = 1'b0;
  endtask

  task automatic wait_fill(input int exp_alpha, input int exp_len);
    int n;
    n = 0;
    while (bus.o_busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check("fill_end_busy", {31'd0, bus.o_busy}, 32'd0);
    if (exp_len >= 0) check("fill_len", n, exp_len);
    check("alpha", {27'd0, bus.o_alpha}, exp_alpha);
  endtask

  initial begin
    bus.i_en    = 1'b1;
    bus.i_vsync = 1'b0;
    bus.i_de    = 1'b0;
    bus.i_y     = 8'd0;
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_o_de",   {31'd0, bus.o_de},    0);
    check("rst_o_y",    {24'd0, bus.o_y},     0);
    check("rst_addr",   {24'd0, bus.o_tab_addr}, 0);
    check("rst_alpha",  {27'd0, bus.o_alpha}, 0);
    check("rst_ready",  {31'd0, bus.o_ready}, 0);
    check("rst_busy",   {31'd0, bus.o_busy},  0);
    rst = 1'b0;

    // Bypass before any swap
    bus.i_de = 1'b1;
    lookup("bypass_y", 8'd37, 8'd37);
    check("bypass_de", {31'd0, bus.o_de}, 1);
    bus.i_de = 1'b0;

    // Frame of zeros (plus the 37 pixel): mean 2 -> alpha 16
    frame_vsync(0, 16, 8'd0);
    check("calc_busy", {31'd0, bus.o_busy}, 1);
    wait_fill(16, 257);

    // Frame of 255s; swap in the pure base curve
    frame_vsync(255, 16, 8'd0);
    check("ready_after_swap", {31'd0, bus.o_ready}, 1);
    lookup("base_1", 8'd1, 8'd2);
    lookup("base_128", 8'd128, 8'd175);
    wait_fill(1, -1);

    // Swap in alpha=1 table; disabled adaptation for the next fill
    bus.i_en = 1'b0;
    frame_vsync(100, 16, 8'd0);
    lookup("a1_128", 8'd128, 8'd130);
    lookup("a1_0", 8'd0, 8'd0);
    lookup("a1_255", 8'd255, 8'd255);
    wait_fill(0, -1);
    bus.i_en = 1'b1;

    // Identity table swapped in; exhaustive pass-through
    frame_vsync(0, 16, 8'd0);
    for (int k = 0; k < 256; k++) lookup("ident", 8'(k), 8'(k));
    wait_fill(16, -1);

    // Abort a fill at cycle 100
    frame_vsync(0, 16, 8'd0);
    tick();
    for (int k = 0; k < 100; k++) tick();
    check("abort_addr", {24'd0, bus.o_tab_addr}, 100);
    bus.i_y     = 8'd128;
    bus.i_vsync = 1'b1;
    tick();
    bus.i_vsync = 1'b0;
    check("abort_old_bank", {24'd0, bus.o_y}, 175);
    check("abort_ready", {31'd0, bus.o_ready}, 1);
    check("abort_busy", {31'd0, bus.o_busy}, 1);
    wait_fill(16, 257);
    lookup("abort_still_old", 8'd1, 8'd2);

    // Back-to-back means 0 then 255: swap-cycle lookup uses old bank
    frame_vsync(255, 16, 8'd0);
    wait_fill(1, 257);
    frame_vsync(0, 0, 8'd128);
    check("swap_old", {24'd0, bus.o_y}, 175);
    lookup("swap_new", 8'd128, 8'd130);

    // Reset in the middle of a fill
    for (int k = 0; k < 50; k++) tick();
    check("midfill_busy", {31'd0, bus.o_busy}, 1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst2_ready", {31'd0, bus.o_ready}, 0);
    check("rst2_busy",  {31'd0, bus.o_busy},  0);
    check("rst2_alpha", {27'd0, bus.o_alpha}, 0);
    check("rst2_addr",  {24'd0, bus.o_tab_addr}, 0);
    bus.i_de = 1'b1;
    lookup("rst2_bypass_y", 8'd37, 8'd37);
    check("rst2_bypass_de", {31'd0, bus.o_de}, 1);
    bus.i_de = 1'b0;
    lookup("rst2_bypass_128", 8'd128, 8'd128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
